// File: rtl/otn_frame_rx_ack_if.sv
// Receive-side delivery bundle of the OTN frame receiver: payload bytes and frame status.
interface otn_frame_rx_ack_if;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_start;
    logic       frame_done;
    logic       frame_good;
    logic       locked;

    modport master (output data, data_valid, frame_start, frame_done, frame_good, locked);
    modport slave  (input  data, data_valid, frame_start, frame_done, frame_good, locked);
endinterface

// File: rtl/otn_frame_rx_ack.sv
// OTN serial frame receiver: bit-timing recovery, FAS hunt, payload delivery,
// BIP-8 check and 3-bit ACK return on the idle-high ACK line.
//
// state      | meaning
// HUNT       | shifting sampled bits, searching for FAS
// RECV       | locked, assembling payload bytes and accumulating BIP
// CHECK      | one cycle: compare received BIP byte, report frame result
// ACK_START  | ACK line driven 0 for one bit time
// ACK_BIT    | ACK line driven with the frame result for one bit time
// ACK_STOP   | ACK line driven 0 for one bit time, then back to HUNT
module otn_frame_rx_ack #(
    parameter int          FRAME_BYTES = 4164,
    parameter int          BIT_TICKS   = 20,
    parameter int          SAMPLE_TICK = 9,
    parameter logic [47:0] FAS         = 48'h282828F6F6F6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sclk_en_16_x_baud,
    input  logic               i_otn_rx_data,
    input  logic               i_arq_en,
    output logic               o_otn_tx_ack,
    otn_frame_rx_ack_if.master rx_if
);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_RECV,
        ST_CHECK,
        ST_ACK_START,
        ST_ACK_BIT,
        ST_ACK_STOP
    } state_t;

    localparam logic [4:0]  PHASE_LAST = 5'(BIT_TICKS - 1);
    localparam logic [4:0]  SAMPLE_PH  = 5'(SAMPLE_TICK);
    localparam logic [4:0]  ACK_LOAD   = 5'(BIT_TICKS - 1);
    localparam logic [12:0] LAST_BYTE  = 13'(FRAME_BYTES - 1);

    state_t      state_q, state_d;
    logic [2:0]  sync_q;
    logic [4:0]  phase_q, phase_d;
    logic [47:0] sreg_q, sreg_d;
    logic [7:0]  byte_sh_q, byte_sh_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [12:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  bip_q, bip_d;
    logic [4:0]  ack_cnt_q, ack_cnt_d;
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_good_q, frame_good_d;
    logic        locked_q, locked_d;
    logic        tx_ack_q, tx_ack_d;

    logic        rx_edge, rx_bit, sample, fas_hit, byte_done, last_byte, ack_tc;
    logic [47:0] sreg_shift;
    logic [7:0]  byte_shift;

    // A tick coinciding with an edge realigns the phase and never samples.
    assign rx_edge    = sync_q[2] ^ sync_q[1];
    assign rx_bit     = sync_q[1];
    assign sample     = i_sclk_en_16_x_baud && !rx_edge && (phase_q == SAMPLE_PH);
    assign sreg_shift = {rx_bit, sreg_q[47:1]};
    assign byte_shift = {rx_bit, byte_sh_q[7:1]};
    assign fas_hit    = sample && (sreg_shift == FAS);
    assign byte_done  = sample && (bit_cnt_q == 3'd7);
    assign last_byte  = (byte_cnt_q == LAST_BYTE);
    assign ack_tc     = i_sclk_en_16_x_baud && (ack_cnt_q == 5'd0);

    always_ff @(posedge i_clk) begin : state_reg
        if (i_rst) state_q <= ST_HUNT;
        else       state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_HUNT:      if (fas_hit) state_d = ST_RECV;
            ST_RECV:      if (byte_done && last_byte) state_d = ST_CHECK;
            ST_CHECK:     state_d = i_arq_en ? ST_ACK_START : ST_HUNT;
            ST_ACK_START: if (ack_tc) state_d = ST_ACK_BIT;
            ST_ACK_BIT:   if (ack_tc) state_d = ST_ACK_STOP;
            ST_ACK_STOP:  if (ack_tc) state_d = ST_HUNT;
            default:      state_d = ST_HUNT;
        endcase
    end

    always_comb begin : outputs
        phase_d       = phase_q;
        sreg_d        = sreg_q;
        byte_sh_d     = byte_sh_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        bip_d         = bip_q;
        ack_cnt_d     = ack_cnt_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_good_d  = frame_good_q;
        locked_d      = locked_q;

        if (rx_edge)
            phase_d = '0;
        else if (i_sclk_en_16_x_baud)
            phase_d = (phase_q == PHASE_LAST) ? 5'd0 : phase_q + 5'd1;

        case (state_q)
            ST_HUNT: begin
                if (sample) sreg_d = sreg_shift;
                if (fas_hit) begin
                    frame_start_d = 1'b1;
                    locked_d      = 1'b1;
                    byte_cnt_d    = 13'd6;
                    bit_cnt_d     = 3'd0;
                    bip_d         = 8'h00;
                end
            end
            ST_RECV: begin
                if (sample) begin
                    byte_sh_d = byte_shift;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                // The final byte of the frame is the BIP itself and is kept in byte_sh for CHECK.
                if (byte_done && !last_byte) begin
                    data_d       = byte_shift;
                    data_valid_d = 1'b1;
                    bip_d        = bip_q ^ byte_shift;
                    byte_cnt_d   = byte_cnt_q + 13'd1;
                end
            end
            ST_CHECK: begin
                frame_good_d = (byte_sh_q == bip_q);
                frame_done_d = 1'b1;
                locked_d     = 1'b0;
                ack_cnt_d    = ACK_LOAD;
                if (!i_arq_en) sreg_d = '0;
            end
            ST_ACK_START, ST_ACK_BIT, ST_ACK_STOP: begin
                if (i_sclk_en_16_x_baud)
                    ack_cnt_d = ack_tc ? ACK_LOAD : ack_cnt_q - 5'd1;
                if (state_q == ST_ACK_STOP && ack_tc) sreg_d = '0;
            end
            default: ;
        endcase

        case (state_d)
            ST_ACK_START, ST_ACK_STOP: tx_ack_d = 1'b0;
            ST_ACK_BIT:                tx_ack_d = frame_good_q;
            default:                   tx_ack_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin : datapath_reg
        if (i_rst) begin
            sync_q        <= '0;
            phase_q       <= '0;
            sreg_q        <= '0;
            byte_sh_q     <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            bip_q         <= '0;
            ack_cnt_q     <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_good_q  <= 1'b0;
            locked_q      <= 1'b0;
            tx_ack_q      <= 1'b1;
        end else begin
            sync_q        <= {sync_q[1:0], i_otn_rx_data};
            phase_q       <= phase_d;
            sreg_q        <= sreg_d;
            byte_sh_q     <= byte_sh_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            bip_q         <= bip_d;
            ack_cnt_q     <= ack_cnt_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_good_q  <= frame_good_d;
            locked_q      <= locked_d;
            tx_ack_q      <= tx_ack_d;
        end
    end

    assign rx_if.data        = data_q;
    assign rx_if.data_valid  = data_valid_q;
    assign rx_if.frame_start = frame_start_q;
    assign rx_if.frame_done  = frame_done_q;
    assign rx_if.frame_good  = frame_good_q;
    assign rx_if.locked      = locked_q;
    assign o_otn_tx_ack      = tx_ack_q;

endmodule
